// File: rtl/astro_input_pkg.sv
// Shared constants for the Astrocade controller front end: joystick bit layout,
// keypad matrix positions, PS/2 scancodes and paddle defaults.
package astro_input_pkg;

    localparam int JOY_RIGHT  = 0;
    localparam int JOY_LEFT   = 1;
    localparam int JOY_DOWN   = 2;
    localparam int JOY_UP     = 3;
    localparam int JOY_TRIG   = 4;
    localparam int JOY_DIGIT0 = 5;
    localparam int JOY_CHAR   = 15;

    // Keypad bank index = column * KP_ROWS + row, columns k0..k3
    localparam int KP_ROWS = 6;
    localparam int KP_C = 0 * KP_ROWS + 0;
    localparam int KP_7 = 0 * KP_ROWS + 1;
    localparam int KP_8 = 1 * KP_ROWS + 1;
    localparam int KP_9 = 2 * KP_ROWS + 1;
    localparam int KP_4 = 0 * KP_ROWS + 2;
    localparam int KP_5 = 1 * KP_ROWS + 2;
    localparam int KP_6 = 2 * KP_ROWS + 2;
    localparam int KP_1 = 0 * KP_ROWS + 3;
    localparam int KP_2 = 1 * KP_ROWS + 3;
    localparam int KP_3 = 2 * KP_ROWS + 3;
    localparam int KP_0 = 1 * KP_ROWS + 4;

    localparam logic [7:0] SC_0    = 8'h45;
    localparam logic [7:0] SC_1    = 8'h16;
    localparam logic [7:0] SC_2    = 8'h1E;
    localparam logic [7:0] SC_3    = 8'h26;
    localparam logic [7:0] SC_4    = 8'h25;
    localparam logic [7:0] SC_5    = 8'h2E;
    localparam logic [7:0] SC_6    = 8'h36;
    localparam logic [7:0] SC_7    = 8'h3D;
    localparam logic [7:0] SC_8    = 8'h3E;
    localparam logic [7:0] SC_9    = 8'h46;
    localparam logic [7:0] SC_BKSP = 8'h66;

    localparam int DEF_PADDLE_DIV  = 14318;
    localparam int DEF_PADDLE_STEP = 4;

    function automatic logic [7:0] joy_column(input logic [15:0] j);
        return {3'b000, j[JOY_TRIG], j[JOY_RIGHT], j[JOY_LEFT], j[JOY_DOWN], j[JOY_UP]};
    endfunction

    function automatic logic [23:0] joy_keypad(input logic [15:0] j);
        logic [23:0] k;
        k       = '0;
        k[KP_0] = j[JOY_DIGIT0 + 0];
        k[KP_1] = j[JOY_DIGIT0 + 1];
        k[KP_2] = j[JOY_DIGIT0 + 2];
        k[KP_3] = j[JOY_DIGIT0 + 3];
        k[KP_4] = j[JOY_DIGIT0 + 4];
        k[KP_5] = j[JOY_DIGIT0 + 5];
        k[KP_6] = j[JOY_DIGIT0 + 6];
        k[KP_7] = j[JOY_DIGIT0 + 7];
        k[KP_8] = j[JOY_DIGIT0 + 8];
        k[KP_9] = j[JOY_DIGIT0 + 9];
        k[KP_C] = j[JOY_CHAR];
        return k;
    endfunction

    // Returns {valid, bank index}; valid is 0 for unmapped scancodes
    function automatic logic [5:0] scan_decode(input logic [7:0] sc);
        case (sc)
            SC_0:    return {1'b1, 5'(KP_0)};
            SC_1:    return {1'b1, 5'(KP_1)};
            SC_2:    return {1'b1, 5'(KP_2)};
            SC_3:    return {1'b1, 5'(KP_3)};
            SC_4:    return {1'b1, 5'(KP_4)};
            SC_5:    return {1'b1, 5'(KP_5)};
            SC_6:    return {1'b1, 5'(KP_6)};
            SC_7:    return {1'b1, 5'(KP_7)};
            SC_8:    return {1'b1, 5'(KP_8)};
            SC_9:    return {1'b1, 5'(KP_9)};
            SC_BKSP: return {1'b1, 5'(KP_C)};
            default: return 6'b0;
        endcase
    endfunction

endpackage

// File: rtl/astro_ctrl_matrix_paddle_slew.sv
// Slew-limited paddle pot: on each tick moves toward target by at most STEP,
// never overshooting.
module paddle_slew
    import astro_input_pkg::*;
#(
    parameter int STEP = DEF_PADDLE_STEP
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       tick,
    input  logic [7:0] target,
    output logic [7:0] pot
);

    logic [8:0] diff_up;
    logic [8:0] diff_dn;
    logic [8:0] step9;

    assign step9   = 9'(STEP);
    assign diff_up = {1'b0, target} - {1'b0, pot};
    assign diff_dn = {1'b0, pot} - {1'b0, target};

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            pot <= 8'h7F;
        end else if (tick) begin
            if (target > pot)
                pot <= pot + 8'((diff_up < step9) ? diff_up : step9);
            else if (pot > target)
                pot <= pot - 8'((diff_dn < step9) ? diff_dn : step9);
        end
    end

endmodule

// File: rtl/astro_ctrl_matrix.sv
// Astrocade controller front end: joysticks, PS/2 keypad bank and slewed paddles
// folded into the registered switch-matrix row and pot values.
module astro_ctrl_matrix
    import astro_input_pkg::*;
#(
    parameter int PADDLE_DIV  = DEF_PADDLE_DIV,
    parameter int PADDLE_STEP = DEF_PADDLE_STEP
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [15:0] joya,
    input  logic [15:0] joyb,
    input  logic [15:0] joyaa,
    input  logic [15:0] joyba,
    input  logic [10:0] ps2_key,
    input  logic [7:0]  col_select,
    output logic [7:0]  row_data,
    input  logic [3:0]  pot_select,
    output logic [7:0]  pot_data
);

    localparam int CNT_W = (PADDLE_DIV > 1) ? $clog2(PADDLE_DIV) : 1;

    logic [23:0]      kb_bank;
    logic             ps2_tog;
    logic             primed;
    logic [5:0]       sc_dec;
    logic             kb_event;
    logic [23:0]      keypad;
    logic [7:0]       row_next;
    logic [CNT_W-1:0] tick_cnt;
    logic             tick;
    logic [7:0]       target0;
    logic [7:0]       target1;
    logic [7:0]       pot0;
    logic [7:0]       pot1;
    logic [7:0]       pot_next;
    logic             unused_inputs;

    // pot2/pot3 are constant zero, so their select bits contribute nothing
    assign unused_inputs = ^{joyaa[7:0], joyba[7:0], pot_select[3:2]};

    assign sc_dec   = scan_decode(ps2_key[7:0]);
    assign kb_event = primed && (ps2_key[10] != ps2_tog) && !ps2_key[8] && sc_dec[5];

    // The first cycle after reset only primes the toggle copy so a held toggle is not an event
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            kb_bank <= '0;
            ps2_tog <= 1'b0;
            primed  <= 1'b0;
        end else begin
            ps2_tog <= ps2_key[10];
            primed  <= 1'b1;
            if (kb_event)
                kb_bank[sc_dec[4:0]] <= ps2_key[9];
        end
    end

    assign keypad = kb_bank | joy_keypad(joya) | joy_keypad(joyb);

    always_comb begin
        row_next = '0;
        if (col_select[0])
            row_next = row_next | joy_column(joya);
        if (col_select[1])
            row_next = row_next | joy_column(joyb);
        for (int c = 0; c < 4; c++) begin
            if (col_select[4 + c])
                row_next = row_next | {2'b00, keypad[c * KP_ROWS +: KP_ROWS]};
        end
    end

    assign tick = (tick_cnt == CNT_W'(PADDLE_DIV - 1));

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

    assign target0 = 8'h7F - joyaa[15:8];
    assign target1 = 8'h7F - joyba[15:8];

    paddle_slew #(.STEP(PADDLE_STEP)) u_pot0 (
        .clk_sys (clk_sys),
        .reset   (reset),
        .tick    (tick),
        .target  (target0),
        .pot     (pot0)
    );

    paddle_slew #(.STEP(PADDLE_STEP)) u_pot1 (
        .clk_sys (clk_sys),
        .reset   (reset),
        .tick    (tick),
        .target  (target1),
        .pot     (pot1)
    );

    assign pot_next = ({8{pot_select[0]}} & pot0) | ({8{pot_select[1]}} & pot1);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            row_data <= '0;
            pot_data <= '0;
        end else begin
            row_data <= row_next;
            pot_data <= pot_next;
        end
    end

endmodule

// File: tb/tb_astro_ctrl_matrix.sv
// Randomized self-checking bench for astro_ctrl_matrix with a behavioural key/pot
// model and literal checks of the documented scenarios.
module tb_astro_ctrl_matrix;

    localparam int DIV  = 4;
    localparam int STEP = 4;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [15:0] joya, joyb, joyaa, joyba;
    logic [10:0] ps2_key;
    logic [7:0]  col_select;
    logic [3:0]  pot_select;
    logic [7:0]  row_data;
    logic [7:0]  pot_data;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    always #5 clk_sys = ~clk_sys;

    astro_ctrl_matrix #(.PADDLE_DIV(DIV), .PADDLE_STEP(STEP)) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .joya       (joya),
        .joyb       (joyb),
        .joyaa      (joyaa),
        .joyba      (joyba),
        .ps2_key    (ps2_key),
        .col_select (col_select),
        .row_data   (row_data),
        .pot_select (pot_select),
        .pot_data   (pot_data)
    );

    // Keys 0..9 are digits, key 10 is Char/C
    localparam logic [7:0] SCAN [11] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
                                         8'h36, 8'h3D, 8'h3E, 8'h46, 8'h66};
    localparam int KCOL [11] = '{1, 0, 1, 2, 0, 1, 2, 0, 1, 2, 0};
    localparam int KROW [11] = '{4, 3, 3, 3, 2, 2, 2, 1, 1, 1, 0};

    bit         kb_held [11];
    bit         m_primed;
    bit         m_tog;
    int         m_cyc;
    int         m_pot [2];
    logic [7:0] exp_row;
    logic [7:0] exp_pot;

    function automatic logic [7:0] hand(input logic [15:0] j);
        logic [7:0] r;
        r    = 8'h00;
        r[0] = j[3];
        r[1] = j[2];
        r[2] = j[1];
        r[3] = j[0];
        r[4] = j[4];
        return r;
    endfunction

    function automatic logic [7:0] model_row();
        logic [7:0] r;
        int         jb;
        r = 8'h00;
        if (col_select[0]) r = r | hand(joya);
        if (col_select[1]) r = r | hand(joyb);
        for (int k = 0; k < 11; k++) begin
            jb = (k < 10) ? 5 + k : 15;
            if ((kb_held[k] || joya[jb] || joyb[jb]) && col_select[4 + KCOL[k]])
                r[KROW[k]] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [7:0] model_pot();
        logic [7:0] r;
        r = 8'h00;
        if (pot_select[0]) r = r | 8'(m_pot[0]);
        if (pot_select[1]) r = r | 8'(m_pot[1]);
        return r;
    endfunction

    function automatic int slew(input int p, input logic [15:0] a);
        int t;
        t = (127 - int'(a[15:8])) & 255;
        if (t > p) return p + ((t - p < STEP) ? t - p : STEP);
        if (p > t) return p - ((p - t < STEP) ? p - t : STEP);
        return p;
    endfunction

    always @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            exp_row  = 8'h00;
            exp_pot  = 8'h00;
            foreach (kb_held[i]) kb_held[i] = 1'b0;
            m_primed = 1'b0;
            m_tog    = 1'b0;
            m_cyc    = 0;
            m_pot[0] = 127;
            m_pot[1] = 127;
        end else begin
            exp_row = model_row();
            exp_pot = model_pot();
            if (m_primed && ps2_key[10] != m_tog && !ps2_key[8]) begin
                for (int k = 0; k < 11; k++)
                    if (SCAN[k] == ps2_key[7:0]) kb_held[k] = ps2_key[9];
            end
            m_tog    = ps2_key[10];
            m_primed = 1'b1;
            if (m_cyc % DIV == DIV - 1) begin
                m_pot[0] = slew(m_pot[0], joyaa);
                m_pot[1] = slew(m_pot[1], joyba);
            end
            m_cyc++;
        end
    end

    task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk_sys) begin
        #2;
        if (check_en) begin
            check_output("model_row", row_data, exp_row);
            check_output("model_pot", pot_data, exp_pot);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_sys);
        #3;
    endtask

    task automatic ps2_event(input bit press, input bit ext, input logic [7:0] sc);
        @(negedge clk_sys);
        ps2_key = {~ps2_key[10], press, ext, sc};
    endtask

    task automatic apply_stimulus(input logic [15:0] a, input logic [15:0] b,
                                  input logic [7:0] col, input logic [3:0] ps);
        @(negedge clk_sys);
        joya       = a;
        joyb       = b;
        col_select = col;
        pot_select = ps;
    endtask

    initial begin
        reset      = 1'b1;
        joya       = '0;
        joyb       = '0;
        joyaa      = '0;
        joyba      = '0;
        ps2_key    = '0;
        col_select = '0;
        pot_select = '0;
        step(3);
        @(negedge clk_sys);
        reset    = 1'b0;
        check_en = 1'b1;
        step(1);
        check_output("reset_row", row_data, 8'h00);

        // Hand controllers and keypad columns driven by the joystick words
        apply_stimulus(16'h0018, 16'h0000, 8'h01, 4'h0);
        step(1); check_output("hand_a_up_trig", row_data, 8'h11);
        apply_stimulus(16'h0018, 16'h0000, 8'h04, 4'h0);
        step(1); check_output("col2_zero", row_data, 8'h00);
        apply_stimulus(16'h0000, 16'h0005, 8'h02, 4'h0);
        step(1); check_output("hand_b_right_down", row_data, 8'h0A);
        apply_stimulus(16'h0000, 16'h1000, 8'h10, 4'h0);
        step(1); check_output("keypad_7", row_data, 8'h02);
        apply_stimulus(16'h0100, 16'h1000, 8'h30, 4'h0);
        step(1); check_output("keypad_k0k1", row_data, 8'h02);
        apply_stimulus(16'h0100, 16'h1000, 8'h50, 4'h0);
        step(1); check_output("keypad_k0k2_or", row_data, 8'h0A);
        apply_stimulus(16'h0100, 16'h1000, 8'h00, 4'h0);
        step(1); check_output("no_column", row_data, 8'h00);

        // Keyboard bank events
        apply_stimulus(16'h0000, 16'h0000, 8'h20, 4'h0);
        step(1);
        ps2_event(1'b1, 1'b0, 8'h3E);
        step(1); check_output("kb_latency1", row_data, 8'h00);
        step(1); check_output("kb_press_8", row_data, 8'h02);
        ps2_event(1'b0, 1'b0, 8'h3E);
        step(2); check_output("kb_release_8", row_data, 8'h00);
        ps2_event(1'b0, 1'b0, 8'h3E);
        step(2); check_output("kb_release_again", row_data, 8'h00);
        ps2_event(1'b1, 1'b1, 8'h3E);
        step(2); check_output("kb_extended", row_data, 8'h00);
        ps2_event(1'b1, 1'b0, 8'h1C);
        step(2); check_output("kb_unmapped", row_data, 8'h00);
        apply_stimulus(16'h0000, 16'h0000, 8'h10, 4'h0);
        ps2_event(1'b1, 1'b0, 8'h66);
        step(2); check_output("kb_backspace_c", row_data, 8'h01);
        ps2_event(1'b0, 1'b0, 8'h66);
        step(2); check_output("kb_backspace_rel", row_data, 8'h00);

        // Keyboard and joystick on the same key
        apply_stimulus(16'h2000, 16'h0000, 8'h20, 4'h0);
        ps2_event(1'b1, 1'b0, 8'h3E);
        step(2); check_output("both_held", row_data, 8'h02);
        ps2_event(1'b0, 1'b0, 8'h3E);
        step(2); check_output("joy_still_held", row_data, 8'h02);
        apply_stimulus(16'h0000, 16'h0000, 8'h20, 4'h0);
        step(1); check_output("both_released", row_data, 8'h00);

        // Toggle held through reset release must not register an event
        @(negedge clk_sys);
        ps2_key = {1'b1, 1'b1, 1'b0, 8'h3E};
        reset   = 1'b1;
        step(2);
        @(negedge clk_sys);
        reset = 1'b0;
        step(3); check_output("prime_no_event", row_data, 8'h00);

        // Paddle slew on pot0
        apply_stimulus(16'h0000, 16'h0000, 8'h00, 4'h1);
        joyaa = 16'h8000;
        step(1);
        for (int i = 0; i < 20 && pot_data == 8'h7F; i++) step(1);
        check_output("pot_first_step", pot_data, 8'h83);
        step(DIV * 40); check_output("pot_top", pot_data, 8'hFF);
        @(negedge clk_sys);
        joyaa = 16'h7D00;
        step(DIV * 75); check_output("pot_down_stop", pot_data, 8'h02);

        // Reset in the middle of a slew
        @(negedge clk_sys);
        joyaa = 16'h8000;
        step(DIV * 5);
        @(negedge clk_sys);
        reset = 1'b1;
        #1 check_output("pot_async_reset", pot_data, 8'h00);
        step(2);
        @(negedge clk_sys);
        reset      = 1'b0;
        pot_select = 4'hC;
        step(1); check_output("pot23_zero", pot_data, 8'h00);
        @(negedge clk_sys);
        pot_select = 4'h1;
        step(1); check_output("pot_after_reset", pot_data, 8'h7F);

        // Random traffic checked by the model every cycle
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk_sys);
            joya       = 16'($urandom) & 16'($urandom) & 16'($urandom);
            joyb       = 16'($urandom) & 16'($urandom) & 16'($urandom);
            col_select = 8'($urandom);
            pot_select = 4'($urandom);
            if ($urandom_range(0, 15) == 0) joyaa = 16'($urandom);
            if ($urandom_range(0, 15) == 0) joyba = 16'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                ps2_key[10]  = ~ps2_key[10];
                ps2_key[9]   = 1'($urandom);
                ps2_key[8]   = ($urandom_range(0, 7) == 0);
                ps2_key[7:0] = ($urandom_range(0, 11) == 11) ? 8'h1C : SCAN[$urandom_range(0, 10)];
            end
        end
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
